// File: rtl/nbit_serial_adder.sv
// Bit-serial N-bit adder: X = A + B + cin, one bit per clock, LSB first.
// start/done handshake, with back-to-back accept from DONE.
module nbit_serial_adder #(
  parameter int unsigned bits = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            cin,
  input  logic [bits-1:0] A,
  input  logic [bits-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [bits-1:0] X,
  output logic            cout
);

  localparam int unsigned cw = (bits > 1) ? $clog2(bits) : 1;
  localparam logic [cw-1:0] last = cw'(bits - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [bits-1:0] a_sr;
  logic [bits-1:0] b_sr;
  logic [bits-1:0] sum_sr;
  logic [cw-1:0]   count;
  logic            carry;

  logic            s;
  logic            c_next;
  logic [bits-1:0] sum_next;

  // Single full-adder cell, time-multiplexed over the operand LSBs.
  always_comb begin
    s        = a_sr[0] ^ b_sr[0] ^ carry;
    c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    sum_next = {s, sum_sr[bits-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      count  <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      X      <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            carry  <= cin;
            sum_sr <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= c_next;
          sum_sr <= sum_next;
          count  <= count + cw'(1);
          if (count == last) begin
            X     <= sum_next;
            cout  <= c_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nbit_serial_adder.sv
// Directed + randomized bench for nbit_serial_adder (8-bit and 5-bit instances),
// checked against plain-arithmetic sums.
module tb_nbit_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, x8;
  logic       start5, cin5, busy5, done5, cout5;
  logic [4:0] a5, b5, x5;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  prev_x8;
  logic        prev_c8;

  always #5 clk = ~clk;

  nbit_serial_adder #(.bits(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .cin(cin8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .X(x8), .cout(cout8)
  );

  nbit_serial_adder #(.bits(5)) u5 (
    .clk(clk), .rst(rst), .start(start5), .cin(cin5), .A(a5), .B(b5),
    .busy(busy5), .done(done5), .X(x5), .cout(cout5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One 8-bit operation; noisy=1 pulses start and scrambles inputs during RUN.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit noisy);
    logic [8:0] ref_sum;
    ref_sum = {1'b0, a} + {1'b0, b} + {8'b0, c};
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("run_busy", busy8, 1'b1);
      check("run_done", done8, 1'b0);
      check("run_hold_x", x8, prev_x8);
      check("run_hold_c", cout8, prev_c8);
      if (noisy) begin
        start8 = (i == 2);
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        cin8 = 1'($urandom);
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    check("done_pulse", done8, 1'b1);
    check("done_busy", busy8, 1'b0);
    check("sum_x", x8, ref_sum[7:0]);
    check("sum_cout", cout8, ref_sum[8]);
    prev_x8 = ref_sum[7:0];
    prev_c8 = ref_sum[8];
    @(negedge clk);
    check("done_single", done8, 1'b0);
    check("idle_busy", busy8, 1'b0);
  endtask

  task automatic op5(input logic [4:0] a, input logic [4:0] b, input logic c);
    logic [5:0] ref_sum;
    ref_sum = {1'b0, a} + {1'b0, b} + {5'b0, c};
    @(negedge clk);
    a5 = a; b5 = b; cin5 = c; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("w5_busy", busy5, 1'b1);
      check("w5_nodone", done5, 1'b0);
      @(negedge clk);
    end
    check("w5_done", done5, 1'b1);
    check("w5_x", x5, ref_sum[4:0]);
    check("w5_cout", cout5, ref_sum[5]);
    @(negedge clk);
    check("w5_done_single", done5, 1'b0);
  endtask

  initial begin
    int unsigned t0, t1, nd;
    logic [8:0] exp_bb [2];

    rst = 1'b1;
    start8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start5 = 1'b0; cin5 = 1'b0; a5 = '0; b5 = '0;
    prev_x8 = '0; prev_c8 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_x", x8, 8'h00);
    check("rst_cout", cout8, 1'b0);
    check("rst_x5", x5, 5'h00);
    rst = 1'b0;

    op8(8'h5A, 8'h3C, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 1'b0);
    op8(8'h10, 8'h20, 1'b0, 1'b1);

    // Back-to-back with start held high.
    exp_bb[0] = 9'h002;
    exp_bb[1] = 9'h100;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80;
    nd = 0; t0 = 0; t1 = 0;
    for (int i = 0; i < 25; i++) begin
      if (done8 === 1'b1) begin
        if (nd < 2) begin
          check("b2b_x", x8, exp_bb[nd][7:0]);
          check("b2b_cout", cout8, exp_bb[nd][8]);
        end
        if (nd == 0) t0 = i; else t1 = i;
        nd++;
      end
      if (nd == 1 && i == t0 + 1) start8 = 1'b0;
      @(negedge clk);
    end
    start8 = 1'b0;
    check("b2b_count", nd, 2);
    check("b2b_spacing", t1 - t0, 9);
    prev_x8 = 8'h00; prev_c8 = 1'b1;

    // Reset asserted at the fourth edge of a run.
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy8, 1'b0);
    check("mid_rst_done", done8, 1'b0);
    check("mid_rst_x", x8, 8'h00);
    check("mid_rst_cout", cout8, 1'b0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 !== 1'b0) nd++;
      @(negedge clk);
    end
    check("mid_rst_nodone", nd, 0);
    prev_x8 = 8'h00; prev_c8 = 1'b0;
    op8(8'h03, 8'h04, 1'b1, 1'b0);

    for (int k = 0; k < 6; k++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), bit'(k % 2));

    op5(5'h1F, 5'h1F, 1'b1);
    for (int k = 0; k < 3; k++)
      op5(5'($urandom), 5'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
